// File: rtl/pkt_ingress_buf.sv
// Ingress packet buffer: stores whole packets with a timestamped head word and
// forwards good packets contiguously to um under pktin_ready back-pressure.
module pkt_ingress_buf #(
    parameter int unsigned DATA_AW       = 8,
    parameter int unsigned VALID_AW      = 4,
    parameter int unsigned MAX_PKT_WORDS = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [133:0]     in_data,
    input  logic             in_data_wr,
    input  logic             in_valid,
    input  logic             in_valid_wr,
    input  logic [47:0]      precision_time,
    output logic [DATA_AW:0] in_usedw,
    output logic [133:0]     pktin_data,
    output logic             pktin_data_wr,
    output logic             pktin_valid,
    output logic             pktin_valid_wr,
    input  logic             pktin_ready,
    output logic [15:0]      drop_cnt
);
    localparam int unsigned DataDepth  = 2 ** DATA_AW;
    localparam int unsigned ValidDepth = 2 ** VALID_AW;
    localparam logic [1:0]  TagHead    = 2'b01;
    localparam logic [1:0]  TagTail    = 2'b10;

    typedef enum logic [1:0] {StIdle, StSend, StDrop} state_e;

    logic [133:0]        data_mem [DataDepth];
    logic [DATA_AW-1:0]  data_wr_ptr_q;
    logic [DATA_AW-1:0]  data_rd_ptr_q;
    logic [DATA_AW:0]    data_cnt_q;

    logic                valid_mem [ValidDepth];
    logic [VALID_AW-1:0] valid_wr_ptr_q;
    logic [VALID_AW-1:0] valid_rd_ptr_q;
    logic [VALID_AW:0]   valid_cnt_q;

    logic                open_q;
    logic                admit_q;
    state_e              state_q;

    logic                data_full, data_empty, data_fits;
    logic                valid_full, valid_empty;
    logic                is_head, admit_now, cur_open, cur_admit;
    logic                data_we, data_re, valid_we, valid_re;
    logic                wr_drop, rd_drop, rd_flag, rd_tail;
    logic [133:0]        data_wdata, rd_word;

    // Counts never exceed the depth, so the MSB alone marks full.
    assign data_full   = data_cnt_q[DATA_AW];
    assign data_empty  = (data_cnt_q == '0);
    assign data_fits   = (32'(data_cnt_q) + MAX_PKT_WORDS) <= DataDepth;
    assign valid_full  = valid_cnt_q[VALID_AW];
    assign valid_empty = (valid_cnt_q == '0);

    // Admission is decided at the head; the same-cycle decision is used when
    // the head itself carries the end-of-packet strobe.
    assign is_head    = in_data_wr && (in_data[133:132] == TagHead);
    assign admit_now  = data_fits && !valid_full;
    assign cur_open   = is_head || open_q;
    assign cur_admit  = is_head ? admit_now : admit_q;

    assign data_we    = in_data_wr && cur_open && cur_admit && !data_full;
    assign valid_we   = in_valid_wr && cur_open && cur_admit;
    assign wr_drop    = in_valid_wr && cur_open && !cur_admit;
    assign data_wdata = is_head ? {in_data[133:48], precision_time} : in_data;

    assign rd_word    = data_mem[data_rd_ptr_q];
    assign rd_tail    = (rd_word[133:132] == TagTail);
    assign rd_flag    = valid_mem[valid_rd_ptr_q];
    assign valid_re   = (state_q == StIdle) && !valid_empty && pktin_ready;
    assign data_re    = (state_q != StIdle) && !data_empty;
    assign rd_drop    = valid_re && !rd_flag;

    assign in_usedw   = data_cnt_q;

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_wr_ptr_q] <= data_wdata;
        end
        if (valid_we) begin
            valid_mem[valid_wr_ptr_q] <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q  <= 1'b0;
            admit_q <= 1'b0;
        end else begin
            if (is_head) begin
                open_q  <= 1'b1;
                admit_q <= admit_now;
            end
            if (in_valid_wr) begin
                open_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_wr_ptr_q  <= '0;
            data_rd_ptr_q  <= '0;
            data_cnt_q     <= '0;
            valid_wr_ptr_q <= '0;
            valid_rd_ptr_q <= '0;
            valid_cnt_q    <= '0;
        end else begin
            if (data_we) begin
                data_wr_ptr_q <= data_wr_ptr_q + DATA_AW'(1);
            end
            if (data_re) begin
                data_rd_ptr_q <= data_rd_ptr_q + DATA_AW'(1);
            end
            unique case ({data_we, data_re})
                2'b10:   data_cnt_q <= data_cnt_q + (DATA_AW + 1)'(1);
                2'b01:   data_cnt_q <= data_cnt_q - (DATA_AW + 1)'(1);
                default: ;
            endcase

            if (valid_we) begin
                valid_wr_ptr_q <= valid_wr_ptr_q + VALID_AW'(1);
            end
            if (valid_re) begin
                valid_rd_ptr_q <= valid_rd_ptr_q + VALID_AW'(1);
            end
            unique case ({valid_we, valid_re})
                2'b10:   valid_cnt_q <= valid_cnt_q + (VALID_AW + 1)'(1);
                2'b01:   valid_cnt_q <= valid_cnt_q - (VALID_AW + 1)'(1);
                default: ;
            endcase
        end
    end

    // Read FSM with registered outputs; returning through StIdle after every
    // tail guarantees an idle output cycle between packets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pktin_data     <= '0;
            pktin_data_wr  <= 1'b0;
            pktin_valid    <= 1'b0;
            pktin_valid_wr <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            pktin_data_wr  <= 1'b0;
            pktin_valid    <= 1'b0;
            pktin_valid_wr <= 1'b0;
            drop_cnt       <= drop_cnt + 16'(wr_drop) + 16'(rd_drop);
            unique case (state_q)
                StIdle: begin
                    if (valid_re) begin
                        state_q <= rd_flag ? StSend : StDrop;
                    end
                end
                StSend: begin
                    if (data_re) begin
                        pktin_data    <= rd_word;
                        pktin_data_wr <= 1'b1;
                        if (rd_tail) begin
                            pktin_valid    <= 1'b1;
                            pktin_valid_wr <= 1'b1;
                            state_q        <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (data_re && rd_tail) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
